// File: rtl/rotate_pkg.sv
// Shared rotate-path definitions: data width, amount width, FSM states.
// Used by both the left and right rotators so both ends agree on width.
package rotate_pkg;

    localparam int WIDTH = 32;
    localparam int AW    = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/rot_left_stage.sv
// One rotator stage: y = rotate-left(data, 2^k) when en, else data.
// Ports: data/en/k in, y out. Purely combinational.
module rot_left_stage #(
    parameter int WIDTH = rotate_pkg::WIDTH,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic [AW-1:0]    k,
    output logic [WIDTH-1:0] y
);

    // Upper half of the shifted doubled word is the rotated word.
    assign y = en ? WIDTH'(({data, data} << (1 << k)) >> WIDTH) : data;

endmodule

// File: rtl/rotate_left_seq.sv
// Iterative left rotator, one amount bit per cycle, valid/ready on both ends.
// Ports: clock, reset_n, in_valid/in_ready/amount/din, out_valid/out_ready/dout, busy.
module rotate_left_seq #(
    parameter int WIDTH = rotate_pkg::WIDTH,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    amount,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    import rotate_pkg::*;

    localparam logic [AW-1:0] KLAST = AW'(AW - 1);

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    k;
    logic [AW-1:0]    amt_r;
    logic [AW-1:0]    kmask;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] stage_out;
    logic [WIDTH-1:0] dout_r;
    logic             en;
    logic             last;

    assign kmask = AW'(1) << k;
    assign en    = |(amt_r & kmask);
    assign last  = (k == KLAST);

    rot_left_stage #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_stage (
        .data (work),
        .en   (en),
        .k    (k),
        .y    (stage_out)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // dout only moves on the final stage, so it is held through IDLE/RUN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k      <= '0;
            amt_r  <= '0;
            work   <= '0;
            dout_r <= '0;
        end else if (state == IDLE && in_valid) begin
            work  <= din;
            amt_r <= amount;
            k     <= '0;
        end else if (state == RUN) begin
            work <= stage_out;
            if (last) begin
                k      <= '0;
                dout_r <= stage_out;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    assign dout = dout_r;

endmodule

// File: tb/tb_rotate_left_seq.sv
// Directed bench for rotate_left_seq: reset, vectors, sweep, backpressure,
// mid-run reset and back-to-back throughput.
module tb_rotate_left_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  amount = '0;
    logic [31:0] din = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] dout;
    logic        busy;

    int total = 0;
    int bad = 0;

    rotate_left_seq dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .amount    (amount),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] d, input int a);
        logic [63:0] t;
        t = {d, d} >> a;
        return t[31:0];
    endfunction

    // Waits for in_ready, accepts one word, returns edges until out_valid.
    task automatic send(input logic [31:0] d, input logic [4:0] a,
                        output int n);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        din = d;
        amount = a;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        din = $urandom;
        amount = 5'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            dout !== 32'h0) begin
            bad++;
            $display("FAIL reset_hold: rdy=%b ov=%b busy=%b dout=%h want 1 0 0 0",
                     in_ready, out_valid, busy, dout);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout !== 32'h0) begin
            bad++;
            $display("FAIL reset_idle: rdy=%b ov=%b dout=%h want 1 0 0",
                     in_ready, out_valid, dout);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vd [5];
        logic [4:0]  va [5];
        logic [31:0] ve [5];
        int n;
        vd[0] = 32'h80000000; va[0] = 5'd1;  ve[0] = 32'h00000001;
        vd[1] = 32'h00000001; va[1] = 5'd31; ve[1] = 32'h80000000;
        vd[2] = 32'h12345678; va[2] = 5'd8;  ve[2] = 32'h34567812;
        vd[3] = 32'hA5A5F00F; va[3] = 5'd0;  ve[3] = 32'hA5A5F00F;
        vd[4] = 32'h81234567; va[4] = 5'd4;  ve[4] = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            send(vd[i], va[i], n);
            total++;
            if (n !== 5) begin
                bad++;
                $display("FAIL vec%0d_latency: got %0d want 5", i, n);
            end
            total++;
            if (dout !== ve[i] || busy !== 1'b1) begin
                bad++;
                $display("FAIL vec%0d_dout: got %h busy=%b want %h busy=1",
                         i, dout, busy, ve[i]);
            end
            drain();
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL vec%0d_release: rdy=%b ov=%b want 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_sweep();
        logic [31:0] d;
        int n;
        for (int a = 0; a < 32; a++) begin
            d = $urandom;
            send(rotr(d, a), 5'(a), n);
            total++;
            if (dout !== d || n !== 5) begin
                bad++;
                $display("FAIL sweep_amt%0d: got %h lat %0d want %h lat 5",
                         a, dout, n, d);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int n;
        send(32'hDEADBEEF, 5'd12, n);
        total++;
        if (dout !== 32'hDBEEFDEA || n !== 5) begin
            bad++;
            $display("FAIL bp_result: got %h lat %0d want dbeefdea lat 5",
                     dout, n);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            din = 32'h0F0F0000 + i;
            amount = 5'(i);
            tick();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                dout !== 32'hDBEEFDEA) begin
                bad++;
                $display("FAIL bp_hold%0d: ov=%b rdy=%b dout=%h want 1 0 dbeefdea",
                         i, out_valid, in_ready, dout);
            end
        end
        in_valid = 1'b0;
        drain();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            dout !== 32'hDBEEFDEA) begin
            bad++;
            $display("FAIL bp_release: rdy=%b ov=%b dout=%h want 1 0 dbeefdea",
                     in_ready, out_valid, dout);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        din = 32'h00000F00;
        amount = 5'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            dout !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset: rdy=%b ov=%b busy=%b dout=%h want 1 0 0 0",
                     in_ready, out_valid, busy, dout);
        end
        tick();
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_discard: bad cycles %0d want 0", seen);
        end
        send(32'h00000F00, 5'd3, n);
        total++;
        if (dout !== 32'h00007800 || n !== 5) begin
            bad++;
            $display("FAIL mid_after: got %h lat %0d want 00007800 lat 5",
                     dout, n);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int wrong;
        logic take;
        wrong = 0;
        din = 32'h000000F0;
        amount = 5'd4;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            take = in_ready;
            tick();
            if (take) acc.push_back(e);
            if (out_valid === 1'b1 && dout !== 32'h00000F00) wrong++;
        end
        in_valid = 1'b0;
        total++;
        if (acc.size() < 4 || acc[1] - acc[0] != 7 || acc[2] - acc[1] != 7) begin
            bad++;
            $display("FAIL b2b_spacing: accepts %0d first gaps not 7", acc.size());
        end
        total++;
        if (wrong != 0) begin
            bad++;
            $display("FAIL b2b_dout: %0d wrong results want 0", wrong);
        end
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle: rdy=%b want 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
